btb_resolve_unit: RTL and testbench
===================================

Name: btb_resolve_unit

Overview:
- Branch-resolution stage that feeds the BTB's writeback-side update port.
- Records the BTB prediction made for each fetched branch in an in-order queue.
- When the branch resolves at writeback, pops the oldest entry and compares prediction against outcome.
- Drives the registered BTB update strobe and, on mispredict, a one-cycle fetch redirect with queue flush and a bounded recovery window.

Parameters:
DEPTH, 4, in-flight prediction entries; power of two, at least 2.
RECOVER_CYC, 2, cycles in RECOVER after a redirect; at least 1.
CNT_W, 16, statistics counter width (BTB_STATS_EN only).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
fetch_push  in  1  branch fetched; capture its prediction.
fetch_pc  in  16  address of the branch instruction.
fetch_btb_hit  in  1  BTB hit at fetch.
fetch_pred_taken  in  1  BTB predictor taken bit at fetch.
fetch_pred_target  in  16  BTB destination at fetch.
fetch_stall  out  1  combinational: fetch_push & full & ~pop_this_cycle.
res_valid  in  1  branch resolved at writeback.
res_pc  in  16  incremented PC of the resolved branch (branch address + 2).
res_taken  in  1  actual branch outcome.
res_target  in  16  actual taken target.
wb_sel  out  1  BTB update strobe, one cycle.
wb_pc  out  16  registered res_pc.
wb_pred_addr  out  16  registered res_target.
wb_btb_hit  out  1  BTB hit recorded at fetch for the branch being updated.
branch_enable  out  1  registered res_taken.
redirect  out  1  one-cycle fetch redirect pulse.
redirect_pc  out  16  correct next PC.
full  out  1  occupancy == DEPTH.
empty  out  1  occupancy == 0.
sync_error  out  1  one-cycle pulse: pop from empty queue, or head PC mismatch.
stat_resolved  out  CNT_W  resolved-branch count.
stat_mispred  out  CNT_W  mispredict count.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs 0; queue empty (empty=1, full=0); FSM in RUN; counters 0.
  - Reset mid-operation discards all entries immediately.
- Queue: circular buffer with head and tail pointers of log2(DEPTH) bits plus an occupancy count (0..DEPTH); pointers wrap modulo DEPTH.
- Push accepted only in RUN when fetch_push & ~fetch_stall.
- Pop on res_valid in RUN; res_valid is ignored in RECOVER.
- Simultaneous push and pop is allowed, including when full; occupancy is unchanged.
- Effective prediction: pt = head.btb_hit & head.pred_taken.
- Mispredict: (pt != res_taken) | (res_taken & pt & head.pred_target != res_target).
- Sync check: head.pc != res_pc - 16'h2 (16-bit wrap arithmetic), or queue empty at pop. Either condition pulses sync_error and is treated as a mispredict.
- Outputs are registered, one cycle after the res_valid edge:
  - wb_sel = res_taken | head.btb_hit. Taken branches allocate; hits update the predictor. An empty-queue pop uses btb_hit=0.
  - wb_pc, wb_pred_addr, branch_enable and wb_btb_hit are held until the next resolve.
  - redirect = mispredict; redirect_pc = res_taken ? res_target : res_pc.
- On a mispredict edge:
  - Queue flushed (head=tail, count=0); any same-cycle push is dropped.
  - FSM goes RUN→RECOVER and loads a down-counter with RECOVER_CYC-1.
- RECOVER: pushes and resolves are ignored and fetch_stall=0. The counter decrements each cycle and the FSM returns to RUN when it reaches 0. A back-to-back mispredict is impossible because resolves are ignored.
- Correct prediction: no redirect; FSM stays in RUN.

Optional Feature:
- BTB_STATS_EN defined:
  - stat_resolved increments on every accepted resolve.
  - stat_mispred increments on every mispredict.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- lc3b_types holds lc3b_word plus a new packed struct btb_pred_entry (pc, btb_hit, pred_taken, pred_target) and typedef enum btb_res_state {RUN, RECOVER}.
- One sub-module: btb_pred_queue, the parameterised FIFO of btb_pred_entry with push/pop/flush, full/empty and count.
- Compare logic, FSM and output registers stay in btb_resolve_unit.

Test Plan:
- Push pc=0x0100 (hit=1, taken=1, target=0x0200); resolve res_pc=0x0102, taken=1, target=0x0200 → next cycle wb_sel=1, wb_btb_hit=1, branch_enable=1, redirect=0, empty=1.
- Push pc=0x0300 (hit=0); resolve res_pc=0x0302, taken=1, target=0x0400 → wb_sel=1, wb_btb_hit=0, redirect=1, redirect_pc=0x0400, RECOVER for 2 cycles.
- Push 4 entries, then a 5th while no pop → fetch_stall=1, full=1, 5th dropped; 5th push concurrent with a resolve → accepted, count stays 4.
- Push 3 entries; resolve the first as not-taken with pred taken → redirect_pc=res_pc, queue empty next cycle, pushes during RECOVER ignored.
- Resolve with empty queue, and resolve with res_pc=0x0500 against head pc=0x0100 → sync_error=1, redirect=1 in both cases.
- With BTB_STATS_EN: 5 resolves including 2 mispredicts → stat_resolved=5, stat_mispred=2; assert reset_n=0 mid-run → all zero asynchronously.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b word type plus the payload and state types of the BTB resolve path.
package lc3b_types;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     btb_hit;
    logic     pred_taken;
    lc3b_word pred_target;
  } btb_pred_entry;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } btb_res_state;

endpackage

// File: rtl/btb_pred_queue.sv
// In-order FIFO of fetch-time BTB predictions awaiting resolution at writeback.
module btb_pred_queue
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  btb_pred_entry                push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output btb_pred_entry                head_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  btb_pred_entry mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

  // Push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i) & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/btb_resolve_unit.sv
// Resolves fetched branches against their BTB predictions and drives BTB update / redirect.
// Optional saturating statistics counters are built when BTB_STATS_EN is defined.
module btb_resolve_unit
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fetch_push,
  input  lc3b_word         fetch_pc,
  input  logic             fetch_btb_hit,
  input  logic             fetch_pred_taken,
  input  lc3b_word         fetch_pred_target,
  output logic             fetch_stall,
  input  logic             res_valid,
  input  lc3b_word         res_pc,
  input  logic             res_taken,
  input  lc3b_word         res_target,
  output logic             wb_sel,
  output lc3b_word         wb_pc,
  output lc3b_word         wb_pred_addr,
  output logic             wb_btb_hit,
  output logic             branch_enable,
  output logic             redirect,
  output lc3b_word         redirect_pc,
  output logic             full,
  output logic             empty,
  output logic             sync_error,
  output logic [CNT_W-1:0] stat_resolved,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int unsigned QCNT_W = $clog2(DEPTH + 1);
  localparam int unsigned RC_W   = $clog2(RECOVER_CYC + 1);

  btb_res_state      state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;

  btb_pred_entry     q_head;
  btb_pred_entry     q_push_data;
  logic              q_full;
  logic              q_empty;
  logic [QCNT_W-1:0] q_count;

  logic     run_c;
  logic     pop_c;
  logic     push_c;
  logic     empty_pop_c;
  logic     sync_err_c;
  logic     hit_c;
  logic     pt_c;
  logic     mispred_c;

  logic     wb_sel_q, wb_btb_hit_q, branch_enable_q, redirect_q, sync_error_q;
  lc3b_word wb_pc_q, wb_pred_addr_q, redirect_pc_q;

  assign run_c = (state_q == RUN);
  assign pop_c = res_valid & run_c;

  assign fetch_stall = run_c & fetch_push & q_full & ~pop_c;
  assign push_c      = run_c & fetch_push & ~fetch_stall & ~mispred_c;

  assign q_push_data = '{pc: fetch_pc, btb_hit: fetch_btb_hit,
                         pred_taken: fetch_pred_taken, pred_target: fetch_pred_target};

  btb_pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_c),
    .push_data_i (q_push_data),
    .pop_i       (pop_c),
    .flush_i     (mispred_c),
    .head_data_o (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  // Compare the oldest prediction with the writeback outcome; a lost sync is a mispredict.
  assign empty_pop_c = (q_count == '0);
  assign sync_err_c  = empty_pop_c | (q_head.pc != (res_pc - 16'h2));
  assign hit_c       = empty_pop_c ? 1'b0 : q_head.btb_hit;
  assign pt_c        = hit_c & q_head.pred_taken;
  assign mispred_c   = pop_c & (sync_err_c | (pt_c != res_taken) |
                                (res_taken & pt_c & (q_head.pred_target != res_target)));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      RUN: begin
        if (mispred_c) begin
          state_d = RECOVER;
          rcnt_d  = RC_W'(RECOVER_CYC - 1);
        end
      end
      RECOVER: begin
        if (rcnt_q == '0) state_d = RUN;
        else              rcnt_d  = rcnt_q - RC_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Strobes pulse for one cycle; payload fields hold until the next resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_sel_q        <= 1'b0;
      redirect_q      <= 1'b0;
      sync_error_q    <= 1'b0;
      wb_btb_hit_q    <= 1'b0;
      branch_enable_q <= 1'b0;
      wb_pc_q         <= '0;
      wb_pred_addr_q  <= '0;
      redirect_pc_q   <= '0;
    end else begin
      wb_sel_q     <= pop_c & (res_taken | hit_c);
      redirect_q   <= mispred_c;
      sync_error_q <= pop_c & sync_err_c;
      if (pop_c) begin
        wb_btb_hit_q    <= hit_c;
        branch_enable_q <= res_taken;
        wb_pc_q         <= res_pc;
        wb_pred_addr_q  <= res_target;
        redirect_pc_q   <= res_taken ? res_target : res_pc;
      end
    end
  end

  assign wb_sel        = wb_sel_q;
  assign wb_btb_hit    = wb_btb_hit_q;
  assign branch_enable = branch_enable_q;
  assign wb_pc         = wb_pc_q;
  assign wb_pred_addr  = wb_pred_addr_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign sync_error    = sync_error_q;
  assign full          = q_full;
  assign empty         = q_empty;

`ifdef BTB_STATS_EN
  logic [CNT_W-1:0] stat_res_q;
  logic [CNT_W-1:0] stat_mis_q;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (pop_c && (stat_res_q != '1))     stat_res_q <= stat_res_q + CNT_W'(1);
      if (mispred_c && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + CNT_W'(1);
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_btb_resolve_unit.sv
// Directed bench for btb_resolve_unit: queue-level reference model checked every cycle.
module tb_btb_resolve_unit;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned RECOVER_CYC = 2;
  localparam int unsigned CNT_W       = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              fetch_push = 1'b0;
  logic [15:0]       fetch_pc = '0;
  logic              fetch_btb_hit = 1'b0;
  logic              fetch_pred_taken = 1'b0;
  logic [15:0]       fetch_pred_target = '0;
  logic              fetch_stall;
  logic              res_valid = 1'b0;
  logic [15:0]       res_pc = '0;
  logic              res_taken = 1'b0;
  logic [15:0]       res_target = '0;
  logic              wb_sel, wb_btb_hit, branch_enable, redirect, full, empty, sync_error;
  logic [15:0]       wb_pc, wb_pred_addr, redirect_pc;
  logic [CNT_W-1:0]  stat_resolved, stat_mispred;

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  btb_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYC(RECOVER_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_push(fetch_push), .fetch_pc(fetch_pc), .fetch_btb_hit(fetch_btb_hit),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
    .fetch_stall(fetch_stall),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .wb_sel(wb_sel), .wb_pc(wb_pc), .wb_pred_addr(wb_pred_addr), .wb_btb_hit(wb_btb_hit),
    .branch_enable(branch_enable), .redirect(redirect), .redirect_pc(redirect_pc),
    .full(full), .empty(empty), .sync_error(sync_error),
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predictions as a plain queue, recovery as cycles remaining.
  typedef struct {
    logic [15:0] pc;
    logic        hit;
    logic        tk;
    logic [15:0] tgt;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_h;
  int          m_rec;
  bit          m_pop, m_stall, m_bad, m_pt, m_mis;
  logic        e_wb_sel, e_redirect, e_sync, e_hit, e_ben;
  logic [15:0] e_wb_pc, e_addr, e_rpc;
  int unsigned e_nres, e_nmis;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_rec = 0;
      e_wb_sel = 0; e_redirect = 0; e_sync = 0; e_hit = 0; e_ben = 0;
      e_wb_pc = 0; e_addr = 0; e_rpc = 0;
      e_nres = 0; e_nmis = 0;
    end else begin
      e_wb_sel = 0; e_redirect = 0; e_sync = 0;
      if (m_rec > 0) begin
        m_rec = m_rec - 1;
      end else begin
        m_pop   = res_valid;
        m_stall = fetch_push && (mq.size() == DEPTH) && !m_pop;
        m_mis   = 0;
        if (m_pop) begin
          if (mq.size() == 0) begin
            m_bad = 1;
            m_h   = '{pc: 16'h0, hit: 1'b0, tk: 1'b0, tgt: 16'h0};
          end else begin
            m_h   = mq[0];
            m_bad = ((m_h.pc + 16'h2) != res_pc);
          end
          m_pt  = m_h.hit && m_h.tk;
          m_mis = m_bad || (m_pt != res_taken) || (m_pt && res_taken && (m_h.tgt != res_target));
          e_wb_sel   = res_taken || m_h.hit;
          e_hit      = m_h.hit;
          e_ben      = res_taken;
          e_wb_pc    = res_pc;
          e_addr     = res_target;
          e_rpc      = res_taken ? res_target : res_pc;
          e_redirect = m_mis;
          e_sync     = m_bad;
          if (e_nres < (32'd1 << CNT_W) - 1) e_nres++;
          if (m_mis && (e_nmis < (32'd1 << CNT_W) - 1)) e_nmis++;
        end
        if (m_mis) begin
          mq.delete();
          m_rec = RECOVER_CYC;
        end else begin
          if (m_pop && mq.size() > 0) void'(mq.pop_front());
          if (fetch_push && !m_stall)
            mq.push_back('{pc: fetch_pc, hit: fetch_btb_hit, tk: fetch_pred_taken,
                           tgt: fetch_pred_target});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_sel", {31'b0, wb_sel}, {31'b0, e_wb_sel});
      chk("wb_btb_hit", {31'b0, wb_btb_hit}, {31'b0, e_hit});
      chk("branch_enable", {31'b0, branch_enable}, {31'b0, e_ben});
      chk("wb_pc", {16'b0, wb_pc}, {16'b0, e_wb_pc});
      chk("wb_pred_addr", {16'b0, wb_pred_addr}, {16'b0, e_addr});
      chk("redirect", {31'b0, redirect}, {31'b0, e_redirect});
      chk("redirect_pc", {16'b0, redirect_pc}, {16'b0, e_rpc});
      chk("sync_error", {31'b0, sync_error}, {31'b0, e_sync});
      chk("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
      chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
      chk("fetch_stall", {31'b0, fetch_stall},
          {31'b0, (m_rec == 0) && fetch_push && (mq.size() == DEPTH) && !res_valid});
`ifdef BTB_STATS_EN
      chk("stat_resolved", 32'(stat_resolved), e_nres);
      chk("stat_mispred", 32'(stat_mispred), e_nmis);
`else
      chk("stat_resolved", 32'(stat_resolved), 32'd0);
      chk("stat_mispred", 32'(stat_mispred), 32'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [15:0] pc, input logic hit, input logic tk,
                           input logic [15:0] tgt);
    fetch_push = 1'b1; fetch_pc = pc; fetch_btb_hit = hit;
    fetch_pred_taken = tk; fetch_pred_target = tgt;
  endtask

  task automatic push(input logic [15:0] pc, input logic hit, input logic tk,
                      input logic [15:0] tgt);
    set_fetch(pc, hit, tk, tgt);
    cyc();
    fetch_push = 1'b0;
  endtask

  task automatic set_res(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    set_res(pc, tk, tgt);
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    idle(2);
    chk("rst_wb_sel", {31'b0, wb_sel}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    reset_n = 1'b1;
    idle(1);

    // Correctly predicted taken hit
    push(16'h0100, 1'b1, 1'b1, 16'h0200);
    resolve(16'h0102, 1'b1, 16'h0200);
    chk("t1_wb_sel", {31'b0, wb_sel}, 32'd1);
    chk("t1_wb_btb_hit", {31'b0, wb_btb_hit}, 32'd1);
    chk("t1_branch_enable", {31'b0, branch_enable}, 32'd1);
    chk("t1_redirect", {31'b0, redirect}, 32'd0);
    chk("t1_empty", {31'b0, empty}, 32'd1);

    // BTB miss on a taken branch: allocate and redirect
    push(16'h0300, 1'b0, 1'b0, 16'h0000);
    resolve(16'h0302, 1'b1, 16'h0400);
    chk("t2_wb_sel", {31'b0, wb_sel}, 32'd1);
    chk("t2_wb_btb_hit", {31'b0, wb_btb_hit}, 32'd0);
    chk("t2_redirect", {31'b0, redirect}, 32'd1);
    chk("t2_redirect_pc", {16'b0, redirect_pc}, 32'h0400);
    idle(3);

    // Fill, stall a fifth push, then accept it alongside a pop
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i * 16), 1'b1, 1'b0, 16'h0);
    set_fetch(16'h1040, 1'b1, 1'b0, 16'h0);
    #1;
    chk("t3_stall", {31'b0, fetch_stall}, 32'd1);
    chk("t3_full", {31'b0, full}, 32'd1);
    cyc();
    set_res(16'h1002, 1'b0, 16'h0);
    #1;
    chk("t3_nostall", {31'b0, fetch_stall}, 32'd0);
    cyc();
    fetch_push = 1'b0; res_valid = 1'b0;
    chk("t3_full_after", {31'b0, full}, 32'd1);
    for (int i = 1; i < 5; i++) resolve(16'h1002 + 16'(i * 16), 1'b0, 16'h0);
    chk("t3_empty", {31'b0, empty}, 32'd1);
    chk("t3_redirect", {31'b0, redirect}, 32'd0);

    // Predicted taken, actually not taken, with younger entries flushed
    push(16'h2000, 1'b1, 1'b1, 16'h2222);
    push(16'h2004, 1'b1, 1'b1, 16'h2222);
    push(16'h2008, 1'b1, 1'b1, 16'h2222);
    resolve(16'h2002, 1'b0, 16'h0);
    chk("t4_redirect", {31'b0, redirect}, 32'd1);
    chk("t4_redirect_pc", {16'b0, redirect_pc}, 32'h2002);
    chk("t4_empty", {31'b0, empty}, 32'd1);
    set_fetch(16'h2100, 1'b1, 1'b0, 16'h0);
    idle(2);
    fetch_push = 1'b0;
    chk("t4_recover_drop", {31'b0, empty}, 32'd1);
    idle(1);

    // Sync errors: empty-queue pop, then head PC mismatch
    resolve(16'h0500, 1'b0, 16'h0);
    chk("t5_sync_empty", {31'b0, sync_error}, 32'd1);
    chk("t5_redirect_empty", {31'b0, redirect}, 32'd1);
    chk("t5_wb_btb_hit", {31'b0, wb_btb_hit}, 32'd0);
    idle(3);
    push(16'h0100, 1'b1, 1'b0, 16'h0);
    resolve(16'h0500, 1'b0, 16'h0);
    chk("t5_sync_pc", {31'b0, sync_error}, 32'd1);
    chk("t5_redirect_pc", {31'b0, redirect}, 32'd1);
    idle(3);

    // Statistics: 5 resolves, 2 mispredicts, from a fresh reset
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    push(16'h3000, 1'b1, 1'b1, 16'h3100);
    resolve(16'h3002, 1'b1, 16'h3100);
    push(16'h3010, 1'b0, 1'b0, 16'h0);
    resolve(16'h3012, 1'b0, 16'h0);
    chk("t6_wb_sel_none", {31'b0, wb_sel}, 32'd0);
    push(16'h3020, 1'b1, 1'b1, 16'h3200);
    resolve(16'h3022, 1'b1, 16'h3300);
    chk("t6_tgt_redirect", {31'b0, redirect}, 32'd1);
    chk("t6_tgt_redirect_pc", {16'b0, redirect_pc}, 32'h3300);
    idle(3);
    push(16'h3030, 1'b1, 1'b0, 16'h0);
    resolve(16'h3032, 1'b0, 16'h0);
    push(16'h3040, 1'b0, 1'b0, 16'h0);
    resolve(16'h3042, 1'b1, 16'h3500);
    idle(2);
`ifdef BTB_STATS_EN
    chk("t6_stat_resolved", 32'(stat_resolved), 32'd5);
    chk("t6_stat_mispred", 32'(stat_mispred), 32'd2);
`else
    chk("t6_stat_resolved", 32'(stat_resolved), 32'd0);
    chk("t6_stat_mispred", 32'(stat_mispred), 32'd0);
`endif

    // Asynchronous reset in the middle of a cycle with an entry in flight
    idle(1);
    push(16'h4000, 1'b1, 1'b1, 16'h4100);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_empty", {31'b0, empty}, 32'd1);
    chk("t7_wb_pc", {16'b0, wb_pc}, 32'd0);
    chk("t7_redirect_pc", {16'b0, redirect_pc}, 32'd0);
    chk("t7_stat_resolved", 32'(stat_resolved), 32'd0);
    chk("t7_stat_mispred", 32'(stat_mispred), 32'd0);
    cyc();
    reset_n = 1'b1;
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
